// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Contents: bytes-per-word constant, fetch FSM state enum, prefetch FIFO entry.
package ifetch_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fifo_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, inst}, synchronous push/pop/flush,
// asynchronous active-high reset. Flush wins over push and pop.
// Ports:
//   clk, rst      clock, async active-high reset
//   push, wr_entry  write wr_entry at the tail (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   flush         empty the FIFO
//   count         current occupancy (0..DEPTH)
//   head          entry at the head (meaningful when count != 0)
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fifo_entry_t                wr_entry,
  output logic [$clog2(DEPTH):0]     count,
  output fifo_entry_t                head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t      mem_q [DEPTH];
  fifo_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch front end. Reads big-endian 32-bit instructions one byte
// per cycle from a byte-wide instruction memory, assembles them, buffers
// {word, pc} in a prefetch FIFO and presents the head over valid/ready.
// Redirects flush everything and restart fetch; misaligned redirects park the
// fetcher in FAULT until an aligned redirect arrives.
// Optional build macro IFETCH_PERF_EN adds perf_words / perf_flushes counters.
// Ports:
//   clk, reset                   clock, async active-high reset
//   redirect_valid, redirect_pc  load new fetch PC and flush
//   imem_req, imem_addr          byte read strobe / byte address
//   imem_rdata                   read byte, valid the cycle after imem_req
//   inst_valid/inst_data/inst_pc FIFO head, inst_ready pops it
//   misalign_fault, fault_pc     last redirect misaligned / offending PC
//   perf_words, perf_flushes     (IFETCH_PERF_EN) push and redirect counters
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IMEM_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [7:0]         imem_rdata,
  output logic               inst_valid,
  output logic [31:0]        inst_data,
  output logic [31:0]        inst_pc,
  input  logic               inst_ready,
  output logic               misalign_fault,
  output logic [31:0]        fault_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_words,
  output logic [15:0]        perf_flushes
`endif
);

  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  issue_pc_q, issue_pc_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic         pend_q, pend_d;
  logic [1:0]   pend_idx_q, pend_idx_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  // Upper three bytes of the word being assembled; byte 3 goes straight in.
  logic [23:0]  asm_q, asm_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic [CNT_W-1:0] fifo_count;
  fifo_entry_t      fifo_head;
  fifo_entry_t      push_entry;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic             fifo_nonempty;
  logic [CNT_W:0]   occupancy;
  logic             issue;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wr_entry (push_entry),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign fifo_nonempty = (fifo_count != '0);

  // Fetch FSM next-state, issue, response capture and FIFO control.
  always_comb begin
    state_d    = state_q;
    issue_pc_d = issue_pc_q;
    byte_idx_d = byte_idx_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_pc_d  = pend_pc_q;
    asm_d      = asm_q;
    fault_pc_d = fault_pc_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    issue      = 1'b0;
    push_entry = '{pc: pend_pc_q, inst: {asm_q, imem_rdata}};
    // A pending response at byte_idx==0 is always byte 3 of a word not yet pushed.
    occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};

    if (redirect_valid) begin
      // Redirect overrides pop, push, response capture and issue.
      fifo_flush = 1'b1;
      byte_idx_d = '0;
      asm_d      = '0;
      issue_pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      fifo_pop = fifo_nonempty && inst_ready;
      if (pend_q) begin
        case (pend_idx_q)
          2'd0:    asm_d[23:16] = imem_rdata;
          2'd1:    asm_d[15:8]  = imem_rdata;
          2'd2:    asm_d[7:0]   = imem_rdata;
          default: fifo_push    = 1'b1;
        endcase
      end
      // A new word starts only when it is guaranteed a free FIFO slot.
      issue = !reset &&
              ((byte_idx_q != '0) || (occupancy < (CNT_W+1)'(DEPTH)));
      if (issue) begin
        pend_d     = 1'b1;
        pend_idx_d = byte_idx_q;
        pend_pc_d  = issue_pc_q;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == LAST_BYTE) begin
          issue_pc_d = issue_pc_q + 32'(BYTES_PER_WORD);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      issue_pc_q <= '0;
      byte_idx_q <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_pc_q  <= '0;
      asm_q      <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      issue_pc_q <= issue_pc_d;
      byte_idx_q <= byte_idx_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_pc_q  <= pend_pc_d;
      asm_q      <= asm_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign imem_req       = issue;
  assign imem_addr      = issue_pc_q[IMEM_AW-1:0] + IMEM_AW'(byte_idx_q);
  assign inst_valid     = fifo_nonempty;
  assign inst_data      = fifo_head.inst;
  assign inst_pc        = fifo_head.pc;
  assign misalign_fault = (state_q == FAULT);
  assign fault_pc       = fault_pc_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_words_q, perf_words_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_words_d   = perf_words_q + 32'(fifo_push);
    perf_flushes_d = perf_flushes_q + 16'(redirect_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_words_q   <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_words_q   <= perf_words_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_words   = perf_words_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: directed scenarios followed by a
// randomized run, every cycle compared against a transaction-level model
// (queue of buffered words, list of words in flight with completion timers).
module tb_ifetch_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic          misalign_fault;
  logic [31:0]   fault_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_words;
  logic [15:0]   perf_flushes;
`endif

  ifetch_prefetch #(.DEPTH(DEPTH), .IMEM_AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .misalign_fault (misalign_fault),
    .fault_pc       (fault_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_words     (perf_words),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Byte-wide instruction memory, one-cycle read latency.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          rem;
  } mword_t;

  mword_t      m_fifo[$];
  mword_t      m_fly[$];
  logic [31:0] m_pc;
  int          m_byte;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  int          m_words;
  int          m_flushes;

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    return mem[a[4:0]];
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_fly.delete();
    m_pc       = '0;
    m_byte     = 0;
    m_fault    = 1'b0;
    m_fault_pc = '0;
    m_words    = 0;
    m_flushes  = 0;
  endtask

  function automatic bit exp_req();
    if (reset || m_fault || redirect_valid) return 1'b0;
    return (m_byte != 0) || ((m_fifo.size() + m_fly.size()) < int'(DEPTH));
  endfunction

  task automatic model_update();
    bit er;
    mword_t w;
    er = exp_req();
    if (reset) begin
      model_reset();
      return;
    end
    if (redirect_valid) begin
      m_flushes++;
      m_fifo.delete();
      m_fly.delete();
      m_byte = 0;
      m_pc   = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault    = 1'b1;
        m_fault_pc = redirect_pc;
      end else begin
        m_fault = 1'b0;
      end
      return;
    end
    if (m_fault) return;
    if (m_fifo.size() != 0 && inst_ready) void'(m_fifo.pop_front());
    foreach (m_fly[i]) m_fly[i].rem--;
    while (m_fly.size() != 0 && m_fly[0].rem == 0) begin
      m_fifo.push_back(m_fly.pop_front());
      m_words++;
    end
    if (er) begin
      if (m_byte == 0) begin
        w.pc   = m_pc;
        w.data = {mem_at(m_pc), mem_at(m_pc + 32'd1), mem_at(m_pc + 32'd2), mem_at(m_pc + 32'd3)};
        w.rem  = 4;
        m_fly.push_back(w);
      end
      m_byte++;
      if (m_byte == 4) begin
        m_byte = 0;
        m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_cycle();
    bit er;
    logic [31:0] a;
    er = exp_req();
    check("imem_req", 32'(imem_req), 32'(er));
    if (reset) begin
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_data", inst_data, 32'd0);
      check("rst_pc", inst_pc, 32'd0);
      check("rst_fault", 32'(misalign_fault), 32'd0);
      check("rst_fault_pc", fault_pc, 32'd0);
    end else begin
      if (er) begin
        a = m_pc + 32'(m_byte);
        check("imem_addr", 32'(imem_addr), {27'd0, a[4:0]});
      end
      check("inst_valid", 32'(inst_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        check("inst_data", inst_data, m_fifo[0].data);
        check("inst_pc", inst_pc, m_fifo[0].pc);
      end
      check("misalign_fault", 32'(misalign_fault), 32'(m_fault));
      check("fault_pc", fault_pc, m_fault_pc);
    end
  endtask

  // One clock: compare mid-cycle, advance model at the edge, return at edge+1.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check({tag, "_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int first;
    logic [31:0] rpc;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    imem_rdata     = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    model_reset();

    // 1: first-word latency and steady throughput
    do_reset();
    inst_ready = 1'b1;
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      if (first < 0 && inst_valid) first = c;
      if (c == 6) begin
        check("t1_data0", inst_data, 32'h0001_0203);
        check("t1_pc0", inst_pc, 32'h0);
      end
      if (c == 10) begin
        check("t1_valid1", 32'(inst_valid), 32'd1);
        check("t1_data1", inst_data, 32'h0405_0607);
        check("t1_pc1", inst_pc, 32'h4);
      end
      step();
    end
    check("t1_first_valid_cycle", 32'(first), 32'd6);

    // 2: backpressure fills the FIFO, then drains in order
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 30; c++) step();
    check("t2_req_idle", 32'(imem_req), 32'd0);
    check("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_pop_pc", inst_pc, 32'(4 * k));
      step();
    end

    // 3: redirect during byte 2 of the word at pc 4
    do_reset();
    inst_ready = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    redirect_to(32'h10);
    wait_valid("t3", ok);
    if (ok) begin
      check("t3_data", inst_data, 32'h1011_1213);
      check("t3_pc", inst_pc, 32'h10);
    end
    for (int c = 0; c < 4; c++) step();

    // 4: misaligned redirect, second misaligned in FAULT, then recovery
    redirect_to(32'h06);
    for (int c = 0; c < 3; c++) step();
    check("t4_fault", 32'(misalign_fault), 32'd1);
    check("t4_fault_pc", fault_pc, 32'h06);
    redirect_to(32'h0A);
    step();
    check("t4_fault_pc2", fault_pc, 32'h0A);
    redirect_to(32'h08);
    check("t4_fault_clear", 32'(misalign_fault), 32'd0);
    wait_valid("t4", ok);
    if (ok) begin
      check("t4_data", inst_data, 32'h0809_0A0B);
      check("t4_pc", inst_pc, 32'h08);
    end

    // 5: byte address wraps within the 32-byte memory
    redirect_to(32'h1C);
    wait_valid("t5a", ok);
    if (ok) begin
      check("t5_data0", inst_data, 32'h1C1D_1E1F);
      check("t5_pc0", inst_pc, 32'h1C);
    end
    step();
    wait_valid("t5b", ok);
    if (ok) begin
      check("t5_data1", inst_data, 32'h0001_0203);
      check("t5_pc1", inst_pc, 32'h20);
    end

    // 6: asynchronous reset mid-word with two buffered words
    do_reset();
    inst_ready = 1'b0;
    for (int c = 0; c < 11; c++) step();
    check("t6_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_addr", 32'(imem_addr), 32'd0);
    check("t6_valid", 32'(inst_valid), 32'd0);
    check("t6_data", inst_data, 32'd0);
    check("t6_pc", inst_pc, 32'd0);
    check("t6_fault", 32'(misalign_fault), 32'd0);
    check("t6_fault_pc", fault_pc, 32'd0);
    step();
    step();
    reset      = 1'b0;
    inst_ready = 1'b1;
    wait_valid("t6", ok);
    if (ok) begin
      check("t6_restart_pc", inst_pc, 32'h0);
      check("t6_restart_data", inst_data, 32'h0001_0203);
    end

    // Randomized phase with fresh memory contents
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      reset          = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 3))
          0:       rpc = 32'($urandom_range(0, 15)) << 2;
          1:       rpc = 32'($urandom_range(0, 63));
          2:       rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
          default: rpc = $urandom() & 32'hFFFF_FFFC;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      step();
    end
    redirect_valid = 1'b0;
    reset          = 1'b0;
    step();
`ifdef IFETCH_PERF_EN
    check("perf_words", perf_words, 32'(m_words));
    check("perf_flushes", 32'(perf_flushes), 32'(16'(m_flushes)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
